// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-count scheduler and its serial engine.
// Holds the FSM state encoding, default sizing and the round-robin reset point.
// No logic; imported by every file of the block.
package ones_count_pkg;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 16;
  localparam int CW_DEF = $clog2(W_DEF + 1);
  localparam int IW_DEF = $clog2(N_DEF);

  // Pointer starts at the last requester so requester 0 wins the first search.
  localparam int RR_RST_DEF = N_DEF - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ones_count_engine.sv
// Serial ones counter: shifts a loaded word out LSB-first, accumulating set bits.
// Latency: W edges after load; done/count are valid combinationally during the W-th bit cycle.
// No backpressure: once loaded it runs to completion; a new load restarts it.
module ones_count_engine
  import ones_count_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_bit_idx;
  logic [CW-1:0] r_acc;
  logic          r_run;

  logic [CW-1:0] w_acc_nxt;
  logic          w_last;

  // count presents the total including the bit consumed this cycle, so the
  // scheduler can register the final value on the same edge as the W-th bit.
  assign w_acc_nxt = r_acc + CW'(r_shreg[0]);
  assign w_last    = r_run && (r_bit_idx == CW'(W - 1));
  assign count     = w_acc_nxt;
  assign done      = w_last;

  // Load a word, then consume one bit per edge until W bits have been counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_acc     <= '0;
      r_run     <= 1'b0;
    end else if (load) begin
      r_shreg   <= din;
      r_bit_idx <= '0;
      r_acc     <= '0;
      r_run     <= 1'b1;
    end else if (r_run) begin
      r_acc     <= w_acc_nxt;
      r_shreg   <= r_shreg >> 1;
      r_bit_idx <= r_bit_idx + CW'(1);
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/ones_count_sched.sv
// Round-robin scheduler sharing one serial ones-count engine among N req/ack requesters.
// Latency: res_valid rises W edges after the ack edge; one word per W+2 cycles with res_ready high.
// Backpressure: result held in DONE until res_ready; no grants are issued while busy.
module ones_count_sched
  import ones_count_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W + 1),
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   ack,
  output logic           res_valid,
  output logic [CW-1:0]  res_count,
  output logic [IW-1:0]  res_id,
  input  logic           res_ready,
  output logic           busy
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_last;
  logic [N-1:0]  r_ack;
  logic          r_res_valid;
  logic [CW-1:0] r_res_count;
  logic [IW-1:0] r_res_id;

  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt;
  logic [IW-1:0] w_idx;
  logic [W-1:0]  w_din;
  logic          w_load;
  logic [CW-1:0] w_eng_count;
  logic          w_eng_done;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(r_last) + k) % N);
      if (!w_gnt_vld && req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // Select the granted requester's word for the engine load.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == IW'(i)) w_din = data[i*W +: W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and engine load; a grant only happens from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_load      = 1'b1;
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (w_eng_done) w_state_nxt = DONE;
      end
      DONE: begin
        if (r_res_valid && res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: ack pulse, RR pointer, and the held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack       <= '0;
      r_last      <= IW'(N - 1);
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_res_id    <= '0;
    end else begin
      r_ack <= w_load ? (N'(1) << w_gnt) : '0;
      if (w_load) begin
        r_last   <= w_gnt;
        r_res_id <= w_gnt;
      end
      if (r_state == COUNT && w_eng_done) begin
        r_res_count <= w_eng_count;
        r_res_valid <= 1'b1;
      end else if (r_state == DONE && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  ones_count_engine #(
    .W  (W),
    .CW (CW)
  ) u_engine (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .din   (w_din),
    .count (w_eng_count),
    .done  (w_eng_done)
  );

  assign ack       = r_ack;
  assign res_valid = r_res_valid;
  assign res_count = r_res_count;
  assign res_id    = r_res_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ones_count_sched.sv
// Self-checking bench for ones_count_sched with a transaction-level reference model.
// Directed scenarios (reset, single, boundary words, fairness, backpressure, mid-run reset) then random traffic.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ones_count_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 5;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic           res_valid;
  logic [CW-1:0]  res_count;
  logic [IW-1:0]  res_id;
  logic           res_ready;
  logic           busy;

  always #5 clk = ~clk;

  ones_count_sched #(.N(N), .W(W), .CW(CW), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .res_valid (res_valid),
    .res_count (res_count),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 free, 1 counting (m_left edges to go), 2 result held.
  int           m_phase = 0;
  int           m_left  = 0;
  int           m_last  = N - 1;
  int           m_cnt   = 0;
  int           m_id    = 0;
  logic         m_vld   = 1'b0;
  logic [N-1:0] exp_ack;

  int           ack_q[$];
  int           res_id_q[$];
  int           res_cnt_q[$];
  logic         p_vld = 1'b0;
  int           p_cnt = 0;
  int           p_id  = 0;

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(5))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h0001;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Advance to the falling edge, apply the edge just taken to the model, compare.
  task automatic cycle();
    int g;
    logic [W-1:0] wd;
    @(negedge clk);
    if (reset && p_vld && res_ready) begin
      res_id_q.push_back(p_id);
      res_cnt_q.push_back(p_cnt);
    end
    exp_ack = '0;
    if (!reset) begin
      m_phase = 0; m_last = N - 1; m_vld = 1'b0;
    end else begin
      case (m_phase)
        0: if (|req) begin
          g = rr_pick(m_last, req);
          exp_ack[g] = 1'b1;
          wd = data[g*W +: W];
          m_cnt = $countones(wd);
          m_id = g; m_last = g; m_left = W; m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_vld = 1'b1; end
        end
        default: if (res_ready) begin m_phase = 0; m_vld = 1'b0; end
      endcase
    end
    chk("ack", ack, exp_ack);
    chk("res_valid", res_valid, m_vld);
    chk("busy", busy, m_phase != 0);
    if (m_vld) begin
      chk("res_count", res_count, m_cnt);
      chk("res_id", res_id, m_id);
    end
    if (!reset) begin
      chk("rst_count", res_count, 0);
      chk("rst_id", res_id, 0);
    end
    for (int i = 0; i < N; i++) if (ack[i]) ack_q.push_back(i);
    p_vld = res_valid; p_cnt = int'(res_count); p_id = int'(res_id);
  endtask

  task automatic wait_ack(input int i, input string tag);
    int t = 0;
    do begin cycle(); t++; end while (ack[i] !== 1'b1 && t < 60);
    chk({tag, "_ack"}, ack[i], 1);
  endtask

  task automatic wait_vld(input string tag);
    int t = 0;
    while (res_valid !== 1'b1 && t < 60) begin cycle(); t++; end
    chk({tag, "_vld"}, res_valid, 1);
  endtask

  task automatic do_word(input int i, input logic [W-1:0] w, input int exp_cnt, input string tag);
    data[i*W +: W] = w;
    req[i] = 1'b1;
    res_ready = 1'b1;
    wait_ack(i, tag);
    req[i] = 1'b0;
    wait_vld(tag);
    chk({tag, "_cnt"}, res_count, exp_cnt);
    chk({tag, "_id"}, res_id, i);
    cycle();
  endtask

  logic [W-1:0] bw [4] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h8000};
  int           bc [4] = '{16, 0, 1, 1};
  int           nres;

  initial begin
    // Reset held with all requests pending: nothing may be granted.
    reset = 1'b0;
    req = '1;
    data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("reset_ack", ack, 0);
      chk("reset_vld", res_valid, 0);
      chk("reset_busy", busy, 0);
    end

    // Fairness with all four requesting continuously.
    ack_q.delete(); res_id_q.delete(); res_cnt_q.delete();
    reset = 1'b1;
    for (int c = 0; c < 80; c++) cycle();
    req = '0;
    for (int c = 0; c < 30; c++) cycle();
    chk("fair_nacks", ack_q.size() >= 5, 1);
    chk("fair_nres", res_id_q.size() >= 4, 1);
    if (ack_q.size() >= 5) begin
      chk("fair_g0", ack_q[0], 0);
      chk("fair_g1", ack_q[1], 1);
      chk("fair_g2", ack_q[2], 2);
      chk("fair_g3", ack_q[3], 3);
      chk("fair_g4", ack_q[4], 0);
    end
    if (res_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("fair_rid", res_id_q[i], i);
        chk("fair_rcnt", res_cnt_q[i], i + 1);
      end
    end

    // Single request from requester 2.
    data[2*W +: W] = 16'hA5F0;
    req = 4'b0100;
    wait_ack(2, "single");
    chk("single_ackvec", ack, 4'b0100);
    req = '0;
    for (int c = 1; c < W; c++) begin
      cycle();
      chk("single_early", res_valid, 0);
    end
    cycle();
    chk("single_vld", res_valid, 1);
    chk("single_cnt", res_count, 8);
    chk("single_id", res_id, 2);
    cycle();
    chk("single_drop", res_valid, 0);

    // Boundary words.
    for (int k = 0; k < 4; k++) do_word(0, bw[k], bc[k], "bound");

    // Backpressure with requester 1 re-requesting while the result is held.
    data[1*W +: W] = 16'h00FF;
    req = 4'b0010;
    res_ready = 1'b0;
    wait_ack(1, "bp");
    wait_vld("bp");
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_vld", res_valid, 1);
      chk("bp_cnt", res_count, 8);
      chk("bp_id", res_id, 1);
      chk("bp_busy", busy, 1);
      chk("bp_noack", ack, 0);
    end
    res_ready = 1'b1;
    cycle();
    chk("bp_drop", res_valid, 0);
    chk("bp_gap", ack, 0);
    cycle();
    chk("bp_regrant", ack, 4'b0010);
    req = '0;
    for (int c = 0; c < 25; c++) cycle();

    // Reset eight cycles into a count: cleared asynchronously, no result.
    data[3*W +: W] = 16'h0F0F;
    req = 4'b1000;
    wait_ack(3, "mid");
    req = '0;
    for (int c = 0; c < 8; c++) cycle();
    nres = res_id_q.size();
    #2 reset = 1'b0;
    #1;
    chk("async_vld", res_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_ack", ack, 0);
    chk("async_cnt", res_count, 0);
    chk("async_id", res_id, 0);
    cycle();
    cycle();
    reset = 1'b1;
    for (int c = 0; c < 25; c++) cycle();
    chk("mid_nores", res_id_q.size(), nres);
    do_word(3, 16'h0F0F, 8, "rereq");

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(3) == 0) data[i*W +: W] = rand_word();
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          data[i*W +: W] = rand_word();
          req[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ones_count_sched.md
Name: ones_count_sched

Overview:
- Round-robin scheduler that shares one serial ones-counting engine among N requesters.
- Each requester offers a W-bit word using a req/ack handshake.
- The scheduler grants one requester, streams the word through the engine one bit per clock, and returns the count tagged with the requester id on a valid/ready result port.
- Sits between the requesting blocks and the bit-counting datapath; it is the only block that drives that datapath.

Parameters:
- N, 4, number of requesters (2..8).
- W, 16, word width in bits.
- CW, 5, count width = clog2(W+1). W=16 gives CW=5, so 16'hFFFF reports 16 without overflow.
- IW, 2, id width = clog2(N).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request; held high with data stable until ack.
- data  in  N*W  requester i's word on bits [i*W +: W].
- ack  out  N  one-hot, one-cycle pulse: word of requester i captured.
- res_valid  out  1  result available.
- res_count  out  CW  number of 1 bits in the granted word.
- res_id  out  IW  index of the requester that owns the result.
- res_ready  in  1  consumer accepts the result when res_valid & res_ready.
- busy  out  1  high in COUNT and DONE.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE; ack=0; res_valid=0; res_count=0; res_id=0; busy=0.
  - Shift register, bit counter and accumulator cleared; RR pointer last=N-1, so requester 0 has highest priority first.
  - Leaving reset is synchronous to clk.
- FSM states IDLE, COUNT, DONE.
- IDLE:
  - If |req at an edge: grant g = first requester with req set, searching from last+1 modulo N.
  - At that same edge: ack[g]=1 for exactly one cycle; shreg<=data[g]; acc<=0; bit_idx<=0; res_id<=g; last<=g; go to COUNT.
  - If no req: stay in IDLE, ack=0.
- COUNT:
  - Each edge: acc<=acc+shreg[0]; shreg<=shreg>>1; bit_idx<=bit_idx+1.
  - After exactly W edges: res_count<=final acc; res_valid<=1; go to DONE.
  - req is ignored in COUNT; no ack is issued.
- DONE:
  - res_valid, res_count and res_id are held stable until res_valid & res_ready.
  - On that edge: res_valid<=0; go to IDLE. No grant is issued on the same edge.
- Latency: res_valid rises W edges after the acceptance edge (the edge at which ack rises). With res_ready tied high, one word completes every W+2 cycles.
- Requester rules:
  - data must be stable while req is high and ack is low.
  - A requester still holding req in the cycle after ack is treated as a new request.
- Simultaneous requests: strictly round-robin; no requester waits more than N-1 grants.
- Reset mid-COUNT or mid-DONE: the in-flight word is discarded, no result is emitted, and the requester must re-request.
- Arithmetic: acc is CW bits wide and cannot overflow because W < 2^CW.

Decomposition:
- Shared package ones_count_pkg holds:
  - the state enum (IDLE, COUNT, DONE);
  - default N and W;
  - CW and IW derived with clog2;
  - RR pointer reset constant N-1.
- One sub-module, ones_count_engine, is natural. It contains the W-bit shift register, the bit_idx counter and the CW-bit accumulator.
  - Inputs: clk, reset, load, din[W-1:0].
  - Outputs: count[CW-1:0], done (one-cycle pulse after the W-th bit).
  - The scheduler handles FSM, arbitration and the handshakes only.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 → ack=0, res_valid=0, res_count=0, res_id=0, busy=0. After release, the first ack is ack=4'b0001.
- Single request: req=4'b0100, data word 2=16'hA5F0, res_ready=1.
  - ack=4'b0100 for one cycle.
  - res_valid rises 16 edges later with res_count=8 and res_id=2, then drops one cycle later.
- Boundary words: 16'hFFFF → res_count=5'b10000 (16); 16'h0000 → 0; 16'h0001 → 1; 16'h8000 → 1.
- Fairness: req=4'b1111 held constant with distinct words (16'h0001, 16'h0003, 16'h0007, 16'h000F).
  - Grant order is 0,1,2,3,0.
  - Results are (id0,1), (id1,2), (id2,3), (id3,4).
  - No ack is issued while busy=1.
- Backpressure: res_ready=0 for 5 cycles after res_valid rises.
  - res_valid, res_count and res_id stay stable; busy=1; no ack although req=4'b0010 is pending.
  - Raise res_ready: res_valid drops at the next edge, and ack=4'b0010 fires on the following edge.
- Reset mid-operation: assert reset=0 eight cycles into COUNT.
  - Outputs clear immediately, without waiting for a clock edge.
  - No result is emitted for that word.
  - After release, a re-request of the same word returns the correct count.
